// File: rtl/lock_actuator_ctrl.sv
// Lock actuator: turns edge-detected lock commands into timed solenoid/siren drives.
// Optional FORCED_ENTRY_EN: door opening while idle raises the alarm.
module lock_actuator_ctrl #(
    parameter int UNLOCK_CYCLES  = 16,
    parameter int ALARM_CYCLES   = 32,
    parameter int LOCKOUT_CYCLES = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] lock_cmd_i,
    input  logic       door_open_i,
    input  logic       alarm_ack_i,
    output logic       solenoid_o,
    output logic       siren_o,
    output logic       busy_o,
    output logic [1:0] status_o
);

    localparam int MAX_UA = (UNLOCK_CYCLES > ALARM_CYCLES) ? UNLOCK_CYCLES : ALARM_CYCLES;
    localparam int MAX_C  = (MAX_UA > LOCKOUT_CYCLES) ? MAX_UA : LOCKOUT_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] UNLOCK_LD  = CW'(UNLOCK_CYCLES - 1);
    localparam logic [CW-1:0] ALARM_LD   = CW'(ALARM_CYCLES - 1);
    localparam logic [CW-1:0] LOCKOUT_LD = CW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNLOCKED,
        S_DOOR_WAIT,
        S_ALARM,
        S_LOCKOUT
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      cmd_prev_q;
    logic            unlock_ev, alarm_ev, force_ev;

    assign unlock_ev = lock_cmd_i[1] & ~cmd_prev_q[1] & ~lock_cmd_i[0];
    assign alarm_ev  = lock_cmd_i[0] & ~cmd_prev_q[0];

`ifdef FORCED_ENTRY_EN
    logic door_prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) door_prev_q <= 1'b0;
        else       door_prev_q <= door_open_i;
    end

    assign force_ev = door_open_i & ~door_prev_q;
`else
    assign force_ev = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cmd_prev_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_prev_q <= lock_cmd_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
        case (state_q)
            S_IDLE: begin
                if (alarm_ev || force_ev) begin
                    state_d = S_ALARM;
                    cnt_d   = ALARM_LD;
                end else if (unlock_ev) begin
                    state_d = S_UNLOCKED;
                    cnt_d   = UNLOCK_LD;
                end
            end
            S_UNLOCKED: begin
                // An open door takes precedence over the window expiring.
                if (alarm_ev) begin
                    state_d = S_ALARM;
                    cnt_d   = ALARM_LD;
                end else if (door_open_i) begin
                    state_d = S_DOOR_WAIT;
                    cnt_d   = '0;
                end else if (unlock_ev) begin
                    cnt_d   = UNLOCK_LD;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_DOOR_WAIT: begin
                if (alarm_ev) begin
                    state_d = S_ALARM;
                    cnt_d   = ALARM_LD;
                end else if (!door_open_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_ALARM: begin
                if (alarm_ack_i || cnt_q == '0) begin
                    state_d = S_LOCKOUT;
                    cnt_d   = LOCKOUT_LD;
                end
            end
            S_LOCKOUT: begin
                if (cnt_q == '0) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign solenoid_o = (state_q == S_UNLOCKED);
    assign siren_o    = (state_q == S_ALARM);
    assign busy_o     = (state_q != S_IDLE);

    always_comb begin
        status_o = 2'b00;
        case (state_q)
            S_UNLOCKED, S_DOOR_WAIT: status_o = 2'b01;
            S_ALARM:                 status_o = 2'b10;
            S_LOCKOUT:               status_o = 2'b11;
            default:                 status_o = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_lock_actuator_ctrl.sv
// Directed bench for lock_actuator_ctrl at default timing (16/32/8 cycles).
module tb_lock_actuator_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cmd;
    logic       door, ack;
    logic       sol, sir, busy;
    logic [1:0] status;

    int n_chk  = 0;
    int n_fail = 0;

    // {solenoid, siren, busy, status}
    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_UNL  = 5'b10101;
    localparam logic [4:0] O_DW   = 5'b00101;
    localparam logic [4:0] O_ALM  = 5'b01110;
    localparam logic [4:0] O_LCK  = 5'b00111;

    lock_actuator_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .lock_cmd_i  (cmd),
        .door_open_i (door),
        .alarm_ack_i (ack),
        .solenoid_o  (sol),
        .siren_o     (sir),
        .busy_o      (busy),
        .status_o    (status)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {sol, sir, busy, status};
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; cmd = 2'b00; door = 1'b0; ack = 1'b0;
        #1 rst = 1'b1;
        #1 chk("reset", O_IDLE);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("post_reset_idle", O_IDLE);

        // unlock held, door closed: 16-cycle window, no retrigger
        cmd = 2'b10;
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("unlock_window", O_UNL);
        end
        cyc();
        chk("unlock_expired", O_IDLE);
        repeat (3) cyc();
        chk("unlock_held_no_retrig", O_IDLE);
        cmd = 2'b00;
        cyc();

        // door opens in the last unlocked cycle: door wins
        cmd = 2'b10;
        for (int i = 0; i < 16; i++) cyc();
        chk("unlock_last_cycle", O_UNL);
        door = 1'b1;
        cyc();
        chk("door_at_zero", O_DW);
        door = 1'b0;
        cyc();
        chk("door_at_zero_close", O_IDLE);
        cmd = 2'b00;
        cyc();

        // door opens in 5th unlocked cycle, held 10 cycles
        cmd = 2'b10;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("unlock_pre_door", O_UNL);
        end
        door = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("door_wait", O_DW);
        end
        door = 1'b0;
        cyc();
        chk("door_closed", O_IDLE);
        cmd = 2'b00;
        cyc();

        // alarm without ack, unlock event during lockout ignored
        cmd = 2'b01;
        for (int i = 0; i < 32; i++) begin
            cyc();
            chk("alarm_siren", O_ALM);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("lockout", O_LCK);
            if (i == 1) cmd = 2'b00;
            if (i == 3) cmd = 2'b10;
        end
        cyc();
        chk("lockout_exit", O_IDLE);
        repeat (2) cyc();
        chk("held_cmd_no_fire", O_IDLE);
        cmd = 2'b00;
        cyc();

        // ack in 3rd alarm cycle
        cmd = 2'b01;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("ack3_siren", O_ALM);
        end
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("ack3_lockout", O_LCK);
        repeat (7) cyc();
        chk("ack3_lockout_last", O_LCK);
        cyc();
        chk("ack3_idle", O_IDLE);
        cmd = 2'b00;
        cyc();

        // ack in first alarm cycle
        cmd = 2'b01;
        cyc();
        chk("ack1_siren", O_ALM);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("ack1_lockout", O_LCK);
        repeat (7) cyc();
        cyc();
        chk("ack1_idle", O_IDLE);
        cmd = 2'b00;
        cyc();

        // 00->11 goes to alarm; async reset mid-alarm
        cmd = 2'b11;
        cyc();
        chk("cmd11_alarm", O_ALM);
        cyc();
        chk("cmd11_alarm_hold", O_ALM);
        #2 rst = 1'b1;
        #1 chk("async_reset", O_IDLE);
        cyc();
        rst = 1'b0;
        cmd = 2'b00;
        cyc();
        chk("reset_release_idle", O_IDLE);

        // door opens while idle
        door = 1'b1;
        cyc();
`ifdef FORCED_ENTRY_EN
        chk("forced_entry", O_ALM);
`else
        chk("idle_door_ignored", O_IDLE);
`endif
        door = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
